// File: rtl/mux_nway_stream_if.sv
// Handshake bundle for mux_nway_stream: NUM producer channels in, one consumer out.
// i_last exists only when MUX_NWAY_LOCK_EN is defined.
interface mux_nway_stream_if #(
    parameter int WIDTH = 16,
    parameter int NUM   = 8
);
    localparam int SELW = $clog2(NUM);

    logic [NUM*WIDTH-1:0] i_data;
    logic [NUM-1:0]       i_valid;
    logic [NUM-1:0]       i_ready;
`ifdef MUX_NWAY_LOCK_EN
    logic [NUM-1:0]       i_last;
`endif
    logic                 mode;
    logic [SELW-1:0]      sel;
    logic [WIDTH-1:0]     o_data;
    logic                 o_valid;
    logic                 o_ready;
    logic [SELW-1:0]      o_sel;

    modport slave (
        input  i_data, i_valid,
`ifdef MUX_NWAY_LOCK_EN
        input  i_last,
`endif
        input  mode, sel, o_ready,
        output i_ready, o_data, o_valid, o_sel
    );

    modport master (
        output i_data, i_valid,
`ifdef MUX_NWAY_LOCK_EN
        output i_last,
`endif
        output mode, sel, o_ready,
        input  i_ready, o_data, o_valid, o_sel
    );
endinterface

// File: rtl/mux_nway_stream.sv
// N-way registered stream mux with fixed-select or round-robin grant.
// Optional packet lock in round-robin mode: define MUX_NWAY_LOCK_EN.
module mux_nway_stream #(
    parameter int WIDTH = 16,
    parameter int NUM   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mux_nway_stream_if.slave  bus
);
    localparam int SELW = $clog2(NUM);

    logic             o_valid_q, o_valid_d;
    logic [WIDTH-1:0] o_data_q, o_data_d;
    logic [SELW-1:0]  o_sel_q, o_sel_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
`ifdef MUX_NWAY_LOCK_EN
    logic             lock_q, lock_d;
`endif

    logic [WIDTH-1:0] ch_data [NUM];
    logic [NUM-1:0]   i_ready_c;
    logic [SELW-1:0]  gnt;
    logic [SELW-1:0]  idx;
    logic             gnt_vld;
    logic             load;
    logic             xfer;

    always_comb begin
        for (int k = 0; k < NUM; k++) begin
            ch_data[k] = bus.i_data[k*WIDTH +: WIDTH];
        end

        load    = !o_valid_q || bus.o_ready;
        gnt     = '0;
        gnt_vld = 1'b0;
        idx     = '0;

        if (!bus.mode) begin
            gnt     = bus.sel;
            gnt_vld = bus.i_valid[bus.sel];
        end
`ifdef MUX_NWAY_LOCK_EN
        // A locked packet keeps the grant on its channel (the last granted one) even while it idles.
        else if (lock_q) begin
            gnt     = ptr_q;
            gnt_vld = bus.i_valid[ptr_q];
        end
`endif
        else begin
            // Offset NUM wraps back to ptr itself, so the last granted channel is checked last.
            for (int k = 1; k <= NUM; k++) begin
                idx = ptr_q + SELW'(k);
                if (!gnt_vld && bus.i_valid[idx]) begin
                    gnt     = idx;
                    gnt_vld = 1'b1;
                end
            end
        end

        xfer      = gnt_vld && load && rst_n;
        i_ready_c = '0;
        if (xfer) begin
            i_ready_c[gnt] = 1'b1;
        end

        o_valid_d = o_valid_q;
        o_data_d  = o_data_q;
        o_sel_d   = o_sel_q;
        ptr_d     = ptr_q;
        if (xfer) begin
            o_valid_d = 1'b1;
            o_data_d  = ch_data[gnt];
            o_sel_d   = gnt;
            ptr_d     = gnt;
        end else if (o_valid_q && bus.o_ready) begin
            o_valid_d = 1'b0;
        end

`ifdef MUX_NWAY_LOCK_EN
        lock_d = lock_q;
        if (!bus.mode) begin
            lock_d = 1'b0;
        end else if (xfer) begin
            lock_d = !bus.i_last[gnt];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_sel_q   <= '0;
            ptr_q     <= SELW'(NUM - 1);
`ifdef MUX_NWAY_LOCK_EN
            lock_q    <= 1'b0;
`endif
        end else begin
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_sel_q   <= o_sel_d;
            ptr_q     <= ptr_d;
`ifdef MUX_NWAY_LOCK_EN
            lock_q    <= lock_d;
`endif
        end
    end

    assign bus.i_ready = i_ready_c;
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_sel   = o_sel_q;

endmodule

// File: tb/tb_mux_nway_stream.sv
// Directed bench for mux_nway_stream (NUM=8, WIDTH=16); channel k always carries k+1.
// Covers the packet-lock behaviour too when MUX_NWAY_LOCK_EN is defined.
module tb_mux_nway_stream;
    localparam int WIDTH = 16;
    localparam int NUM   = 8;

    typedef struct {
        logic        rst_n;
        logic        mode;
        logic [2:0]  sel;
        logic [7:0]  valid;
        logic        o_ready;
        logic [7:0]  exp_ir;
        logic        exp_ov;
        logic [15:0] exp_od;
        logic [2:0]  exp_os;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;
    vec_t vt[$];

    mux_nway_stream_if #(.WIDTH(WIDTH), .NUM(NUM)) bus ();

    mux_nway_stream #(.WIDTH(WIDTH), .NUM(NUM)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic m, input logic [2:0] s,
                         input logic [7:0] v, input logic ordy);
        rst_n       = r;
        bus.mode    = m;
        bus.sel     = s;
        bus.i_valid = v;
        bus.o_ready = ordy;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ov, input logic [15:0] od,
                             input logic [2:0] os);
        check({tag, " o_valid"}, 32'(bus.o_valid), 32'(ov));
        check({tag, " o_data"},  32'(bus.o_data),  32'(od));
        check({tag, " o_sel"},   32'(bus.o_sel),   32'(os));
    endtask

    task automatic apply(input int i, input vec_t v);
        string tag;
        tag = $sformatf("vec%0d", i);
        drive(v.rst_n, v.mode, v.sel, v.valid, v.o_ready);
        #1;
        check({tag, " i_ready"}, 32'(bus.i_ready), 32'(v.exp_ir));
        tick();
        check_out(tag, v.exp_ov, v.exp_od, v.exp_os);
    endtask

    initial begin
        logic [7:0] oh;
        for (int k = 0; k < NUM; k++) begin
            bus.i_data[k*WIDTH +: WIDTH] = 16'(k + 1);
        end
`ifdef MUX_NWAY_LOCK_EN
        bus.i_last = '0;
`endif

        // Reset with a channel offering data: i_ready must stay low.
        drive(1'b0, 1'b0, 3'd0, 8'hFF, 1'b1);
        #1;
        check("reset i_ready", 32'(bus.i_ready), 32'h0);
        tick();
        tick();
        check_out("reset", 1'b0, 16'h0, 3'd0);

        for (int s = 0; s < 8; s++) begin
            oh = 8'd1 << s;
            vt.push_back('{1'b1, 1'b0, 3'(s), 8'hFF, 1'b1, oh, 1'b1, 16'(s + 1), 3'(s)});
        end
        vt.push_back('{1'b0, 1'b1, 3'd0, 8'hFF, 1'b1, 8'h00, 1'b0, 16'h0, 3'd0});
        for (int g = 0; g < 9; g++) begin
            oh = 8'd1 << (g % 8);
            vt.push_back('{1'b1, 1'b1, 3'd0, 8'hFF, 1'b1, oh, 1'b1, 16'((g % 8) + 1), 3'(g % 8)});
        end
        vt.push_back('{1'b1, 1'b0, 3'd3, 8'hF7, 1'b1, 8'h00, 1'b0, 16'd1, 3'd0});
        vt.push_back('{1'b1, 1'b0, 3'd5, 8'h24, 1'b1, 8'h20, 1'b1, 16'd6, 3'd5});
        vt.push_back('{1'b1, 1'b1, 3'd0, 8'h24, 1'b1, 8'h04, 1'b1, 16'd3, 3'd2});
        vt.push_back('{1'b1, 1'b1, 3'd0, 8'h24, 1'b1, 8'h20, 1'b1, 16'd6, 3'd5});
        vt.push_back('{1'b1, 1'b1, 3'd0, 8'h24, 1'b1, 8'h04, 1'b1, 16'd3, 3'd2});

        foreach (vt[i]) apply(i, vt[i]);

        // Backpressure: word 3 from channel 2 held; mode/sel wiggle must not disturb it.
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, c[0], 3'(c + 4), 8'hFF, 1'b0);
            #1;
            check($sformatf("stall%0d i_ready", c), 32'(bus.i_ready), 32'h0);
            tick();
            check_out($sformatf("stall%0d", c), 1'b1, 16'd3, 3'd2);
        end
        drive(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
        #1;
        check("release i_ready", 32'(bus.i_ready), 32'h08);
        tick();
        check_out("release", 1'b1, 16'd4, 3'd3);
        drive(1'b1, 1'b1, 3'd0, 8'h00, 1'b1);
        tick();
        check_out("drain", 1'b0, 16'd4, 3'd3);

        // Reset while stalled full.
        drive(1'b1, 1'b0, 3'd4, 8'hFF, 1'b0);
        tick();
        check_out("preload", 1'b1, 16'd5, 3'd4);
        drive(1'b0, 1'b0, 3'd4, 8'hFF, 1'b0);
        tick();
        check_out("stall reset", 1'b0, 16'h0, 3'd0);
        drive(1'b1, 1'b1, 3'd0, 8'hFF, 1'b1);
        #1;
        check("post-reset i_ready", 32'(bus.i_ready), 32'h01);
        tick();
        check_out("post-reset", 1'b1, 16'd1, 3'd0);

`ifdef MUX_NWAY_LOCK_EN
        // Channel 3 sends a 3-word packet with an idle gap; channel 4 waits throughout.
        drive(1'b0, 1'b1, 3'd0, 8'h00, 1'b1);
        tick();
        drive(1'b1, 1'b1, 3'd0, 8'h18, 1'b1);
        #1;
        check("lock w1 i_ready", 32'(bus.i_ready), 32'h08);
        tick();
        check_out("lock w1", 1'b1, 16'd4, 3'd3);
        drive(1'b1, 1'b1, 3'd0, 8'h10, 1'b1);
        #1;
        check("lock idle i_ready", 32'(bus.i_ready), 32'h00);
        tick();
        drive(1'b1, 1'b1, 3'd0, 8'h18, 1'b1);
        #1;
        check("lock w2 i_ready", 32'(bus.i_ready), 32'h08);
        tick();
        bus.i_last = 8'h08;
        #1;
        check("lock w3 i_ready", 32'(bus.i_ready), 32'h08);
        tick();
        check_out("lock w3", 1'b1, 16'd4, 3'd3);
        bus.i_last = 8'h00;
        #1;
        check("unlock i_ready", 32'(bus.i_ready), 32'h10);
        tick();
        check_out("unlock", 1'b1, 16'd5, 3'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
